// File: rtl/afilt_pkg.sv
// Shared widths, state encoding and MAC helper for the audio filter blocks.
package afilt_pkg;

    localparam int DATA_W = 14;
    localparam int COEF_W = 14;
    localparam int N_TAPS = 4;
    localparam int ACC_W  = 30;
    localparam int FRAC   = 13;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int TAP_W  = $clog2(N_TAPS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    function automatic acc_t mac_term(input sample_t x, input coef_t c);
        prod_t p;
        p = x * c;
        return acc_t'(p);
    endfunction

endpackage

// File: rtl/fir_sat.sv
// Q-format rescale of the accumulator: floor shift by FRAC, clamp to sample range.
module fir_sat
    import afilt_pkg::*;
(
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic signed [DATA_W-1:0] sat_o
);

    localparam int SH_W = ACC_W - FRAC;

    logic signed [SH_W-1:0] sh;
    logic                   pos_ovf;
    logic                   neg_ovf;

    // Dropping the low FRAC bits of a two's-complement value is a floor divide.
    assign sh      = acc_i[ACC_W-1:FRAC];
    assign pos_ovf = !sh[SH_W-1] && (|sh[SH_W-2:DATA_W-1]);
    assign neg_ovf =  sh[SH_W-1] && !(&sh[SH_W-2:DATA_W-1]);

    always_comb begin
        sat_o = sh[DATA_W-1:0];
        if (pos_ovf) begin
            sat_o = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (neg_ovf) begin
            sat_o = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/fir_mac4.sv
// 4-tap FIR with one shared multiplier, one tap per cycle, 6-cycle sample period.
module fir_mac4
    import afilt_pkg::*;
(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     in_ready,
    input  logic                     coef_wr,
    input  logic [TAP_W-1:0]         coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data
);

    state_e               state_q, state_d;
    sample_t              x_q [N_TAPS];
    sample_t              x_d [N_TAPS];
    coef_t                c_q [N_TAPS];
    coef_t                c_d [N_TAPS];
    acc_t                 acc_q, acc_d;
    logic [TAP_W-1:0]     tap_q, tap_d;
    sample_t              out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    sample_t              sat_res;

    fir_sat u_sat (
        .acc_i (acc_q),
        .sat_o (sat_res)
    );

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        c_d         = c_q;
        acc_d       = acc_q;
        tap_d       = tap_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        in_ready    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                // Write lands before MAC reads c, so a same-cycle sample sees it.
                if (coef_wr) begin
                    c_d[coef_addr] = coef_data;
                end
                if (in_valid) begin
                    for (int k = N_TAPS - 1; k > 0; k--) begin
                        x_d[k] = x_q[k-1];
                    end
                    x_d[0]  = in_data;
                    acc_d   = '0;
                    tap_d   = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + mac_term(x_q[tap_q], c_q[tap_q]);
                tap_d = tap_q + TAP_W'(1);
                if (tap_q == TAP_W'(N_TAPS - 1)) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                out_data_d  = sat_res;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            tap_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < N_TAPS; k++) begin
                x_q[k] <= '0;
                c_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            tap_q       <= tap_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            x_q         <= x_d;
            c_q         <= c_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_fir_mac4.sv
// Directed + randomized bench for fir_mac4 against an arithmetic FIR model.
module tb_fir_mac4;

    logic               clk = 1'b0;
    logic               rstn;
    logic               in_valid;
    logic signed [13:0] in_data;
    logic               in_ready;
    logic               coef_wr;
    logic [1:0]         coef_addr;
    logic signed [13:0] coef_data;
    logic               out_valid;
    logic signed [13:0] out_data;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int coef_m [4];
    int hist_m [4];
    int expq [$];

    always #5 clk = ~clk;

    fir_mac4 dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .coef_wr   (coef_wr),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_y();
        longint s;
        longint q;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            s += longint'(coef_m[k]) * longint'(hist_m[k]);
        end
        q = s / 8192;
        if (s < 0 && (s % 8192) != 0) q -= 1;
        if (q > 8191) q = 8191;
        if (q < -8192) q = -8192;
        return int'(q);
    endfunction

    function automatic void model_push(input int x);
        for (int k = 3; k > 0; k--) hist_m[k] = hist_m[k-1];
        hist_m[0] = x;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < 4; k++) begin
            coef_m[k] = 0;
            hist_m[k] = 0;
        end
    endfunction

    function automatic int r14();
        logic signed [13:0] v;
        v = 14'($urandom);
        return int'(v);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rstn     = 1'b0;
        in_valid = 1'b0;
        coef_wr  = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        model_clear();
    endtask

    task automatic wr_coef(input int a, input int d);
        @(negedge clk);
        coef_wr   = 1'b1;
        coef_addr = 2'(a);
        coef_data = 14'(d);
        @(posedge clk);
        #1 coef_wr = 1'b0;
        coef_m[a] = d;
    endtask

    task automatic send(input int x, input bit sim_wr, input int sim_val,
                        input bit mac_wr);
        int  exp;
        int  lat;
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        in_data  = 14'(x);
        if (sim_wr) begin
            coef_wr   = 1'b1;
            coef_addr = 2'd0;
            coef_data = 14'(sim_val);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        coef_wr  = 1'b0;
        if (sim_wr) coef_m[0] = sim_val;
        model_push(x);
        exp = model_y();
        if (mac_wr) begin
            coef_wr   = 1'b1;
            coef_addr = 2'd0;
            coef_data = 14'sd8191;
        end
        lat = -1;
        for (int i = 1; i <= 12 && lat < 0; i++) begin
            @(posedge clk);
            #1;
            coef_wr = 1'b0;
            if (out_valid) lat = i;
        end
        chk("latency", lat, 5);
        chk("out_data", out_data, exp);
        @(posedge clk);
        #1;
        chk("pulse_width", out_valid, 0);
        chk("out_hold", out_data, exp);
    endtask

    initial begin
        int last;
        int naccept;
        int nvalid;
        bit acc;
        rstn      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        coef_wr   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);

        // scaling
        wr_coef(0, 4096);
        send(1000, 0, 0, 0);
        chk("scale_500", out_data, 500);

        // impulse response
        do_reset();
        wr_coef(0, 1000);
        wr_coef(1, 2000);
        wr_coef(2, 3000);
        wr_coef(3, 4000);
        send(4096, 0, 0, 0);
        chk("imp0", out_data, 500);
        send(0, 0, 0, 0);
        chk("imp1", out_data, 1000);
        send(0, 0, 0, 0);
        chk("imp2", out_data, 1500);
        send(0, 0, 0, 0);
        chk("imp3", out_data, 2000);
        send(0, 0, 0, 0);
        chk("imp4", out_data, 0);

        // saturation
        for (int k = 0; k < 4; k++) wr_coef(k, 8191);
        for (int i = 0; i < 4; i++) send(8191, 0, 0, 0);
        chk("pos_sat", out_data, 8191);
        for (int i = 0; i < 4; i++) send(-8192, 0, 0, 0);
        chk("neg_sat", out_data, -8192);

        // coefficient gating and same-cycle write
        do_reset();
        wr_coef(0, 4096);
        send(1000, 0, 0, 1);
        chk("gate_mac0", out_data, 500);
        send(2000, 0, 0, 0);
        chk("gate_mac1", out_data, 1000);
        send(1000, 1, -8192, 0);
        chk("sim_wr", out_data, -1000);

        // backpressure: in_valid held high
        for (int k = 0; k < 4; k++) wr_coef(k, r14());
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 14'(r14());
        last     = -1;
        naccept  = 0;
        for (int c = 0; c < 38; c++) begin
            if (c > 0) @(negedge clk);
            acc = in_ready;
            if (acc) begin
                if (last >= 0) chk("accept_gap", c - last, 6);
                last = c;
                naccept++;
                model_push(int'(in_data));
                expq.push_back(model_y());
            end
            @(posedge clk);
            #1;
            if (out_valid) begin
                if (expq.size() > 0) chk("bp_out", out_data, expq.pop_front());
                else chk("bp_spurious", 1, 0);
            end
            if (acc) in_data = 14'(r14());
        end
        in_valid = 1'b0;
        chk("bp_accepts", naccept, 7);
        for (int i = 0; i < 10 && expq.size() > 0; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) chk("bp_drain_out", out_data, expq.pop_front());
        end
        chk("bp_drained", expq.size(), 0);

        // mid-operation reset
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 14'sd1000;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        model_clear();
        chk("mrst_ready", in_ready, 1);
        chk("mrst_data", out_data, 0);
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) nvalid++;
        end
        chk("mrst_no_pulse", nvalid, 0);
        chk("mrst_data_hold", out_data, 0);
        wr_coef(0, 4096);
        send(1000, 0, 0, 0);
        chk("mrst_500", out_data, 500);

        // randomized coefficients and samples
        do_reset();
        for (int k = 0; k < 4; k++) wr_coef(k, r14());
        for (int i = 0; i < 12; i++) send(r14(), 0, 0, 0);
        send(r14(), 1, r14(), 0);
        send(r14(), 0, 0, 1);
        send(r14(), 0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fir_mac4.md
FIR_MAC4 -- requirements
Module: fir_mac4

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: new sample offered.
REQ-004 SHALL have port in_data, input, 14 bits: signed two's-complement sample, Q1.13.
REQ-005 SHALL have port in_ready, output, 1 bit: sample accepted this cycle when in_valid and in_ready are both high.
REQ-006 SHALL have port coef_wr, input, 1 bit: coefficient write strobe.
REQ-007 SHALL have port coef_addr, input, 2 bits: tap index 0..3.
REQ-008 SHALL have port coef_data, input, 14 bits: signed coefficient, Q1.13.
REQ-009 SHALL have port out_valid, output, 1 bit: one-cycle pulse marking out_data as new.
REQ-010 SHALL have port out_data, output, 14 bits: signed filter result, Q1.13; feeds the downstream DIV halving stage.

Function
REQ-011 SHALL compute y = sum over k=0..3 of c[k]*x[k], where x[0] is the newest accepted sample and x[3] the oldest.
REQ-012 SHALL use a single time-multiplexed 14x14 signed multiplier with a 28-bit product and a 30-bit signed accumulator.
REQ-013 SHALL implement the FSM states IDLE, MAC and OUT.
REQ-014 SHALL, in IDLE, drive in_ready=1; on acceptance it SHALL shift the delay line (x[3]<=x[2] .. x[0]<=in_data), clear the accumulator, and go to MAC.
REQ-015 SHALL, in MAC, accumulate exactly one tap per cycle (k=0,1,2,3) for 4 cycles, then go to OUT; in_ready=0.
REQ-016 SHALL, in OUT, register out_data, assert out_valid for exactly one cycle, and return to IDLE; in_ready=0.
REQ-017 SHALL have a latency of 5 cycles: a sample accepted at edge N gives out_valid high during the cycle after edge N+5; maximum throughput is one sample per 6 cycles.
REQ-018 SHALL form the result as acc arithmetically shifted right by 13 (truncation toward minus infinity), saturated to [-8192, 8191].
REQ-019 SHALL hold out_data at its last value between out_valid pulses.
REQ-020 SHALL accept coef_wr only in IDLE and ignore it in MAC or OUT.
REQ-021 SHALL, when coef_wr and in_valid occur in the same IDLE cycle, apply the coefficient write at that edge, so the computation started at that edge uses the new coefficient.
REQ-022 SHALL not lose or duplicate samples: in_valid while in_ready=0 is ignored, and the source must hold the sample.

Reset
REQ-023 SHALL, when rstn=0 at a rising edge, set state to IDLE and clear x[0..3], c[0..3], the accumulator, out_data (0) and out_valid (0).
REQ-024 SHALL, on reset in MAC or OUT, abandon the computation without producing an out_valid pulse; in_ready SHALL be 1 on the first cycle after reset release.

Structure
REQ-025 SHALL take DATA_W=14, COEF_W=14, N_TAPS=4, ACC_W=30, FRAC=13 and the state enumeration from the shared package afilt_pkg.
REQ-026 SHALL place the shift-and-saturate logic in the sub-module fir_sat (30-bit input, 14-bit output).

Verification
REQ-027 SHALL verify scaling: c0=4096, c1..c3=0, input 1000 -> out_data=500, with out_valid exactly 5 cycles after acceptance.
REQ-028 SHALL verify impulse response: c={1000,2000,3000,4000}, inputs 4096,0,0,0,0 -> outputs 500,1000,1500,2000,0.
REQ-029 SHALL verify positive saturation: all c=8191, four inputs of 8191 -> fourth out_data=8191 (raw result 32760).
REQ-030 SHALL verify negative saturation: all c=8191, four inputs of -8192 -> fourth out_data=-8192.
REQ-031 SHALL verify backpressure and coefficient gating: in_valid held high continuously -> samples accepted only every 6 cycles; coef_wr during MAC -> coefficient unchanged.
REQ-032 SHALL verify mid-operation reset: rstn=0 for 1 cycle during MAC -> no out_valid pulse, out_data=0, and next input 1000 with c0=4096 rewritten -> 500.
